// File: rtl/yolo_params_pkg.sv
// yolo_params_pkg: shared YOLO convolution parameters, derived-size helpers and the
// conv_stream_engine FSM state type.
package yolo_params_pkg;

   localparam int IP_DATA_WIDTH = 8;
   localparam int IFMAP_SIZE    = 8;
   localparam int FILTER_SIZE   = 3;
   localparam int STRIDE        = 1;
   localparam int NUM_CH        = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2
   } conv_state_e;

   function automatic int ofmap_size(input int ifm, input int fs, input int st);
      return (ifm - fs) / st + 1;
   endfunction

   // Full-width adder tree: one product width plus the growth of summing every tap.
   function automatic int acc_width(input int dw, input int fs, input int nch);
      return 2 * dw + $clog2(fs * fs * nch);
   endfunction

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: per-channel raster delay line whose taps present the FxF window
// ending at the current pixel; everything advances only on the shared enable.
module conv_line_buffer
   import yolo_params_pkg::*;
#(
   parameter int DW  = 8,
   parameter int IFM = 8,
   parameter int FS  = 3,
   parameter int NCH = 2
)(
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              en_i,
   input  logic [NCH-1:0][DW-1:0]            pix_i,
   output logic [NCH-1:0][FS*FS-1:0][DW-1:0] win_o
);

   // F-1 full rows plus F-1 pixels of the current row: the tail of each row segment
   // doubles as the window column shift register.
   localparam int DEPTH = (FS - 1) * IFM + FS - 1;

   logic [NCH-1:0][DEPTH-1:0][DW-1:0] dly_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dly_q <= '0;
      end else if (en_i) begin
         for (int c = 0; c < NCH; c++) begin
            dly_q[c][0] <= pix_i[c];
            for (int k = 1; k < DEPTH; k++)
               dly_q[c][k] <= dly_q[c][k-1];
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      for (genvar wr = 0; wr < FS; wr++) begin : g_row
         for (genvar wc = 0; wc < FS; wc++) begin : g_col
            localparam int D = (FS - 1 - wr) * IFM + (FS - 1 - wc);
            if (D == 0) begin : g_cur
               assign win_o[c][wr*FS+wc] = pix_i[c];
            end else begin : g_dly
               assign win_o[c][wr*FS+wc] = dly_q[c][D-1];
            end
         end
      end
   end

endmodule

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: streaming multi-channel FxF convolution, valid/ready in and out,
// multiply / sum / output pipeline. Define CONV_SAT_EN to clamp out_data to 2*IP_DATA_WIDTH bits.
module conv_stream_engine
   import yolo_params_pkg::*;
#(
   parameter int  IP_DATA_WIDTH = yolo_params_pkg::IP_DATA_WIDTH,
   parameter int  IFMAP_SIZE    = yolo_params_pkg::IFMAP_SIZE,
   parameter int  FILTER_SIZE   = yolo_params_pkg::FILTER_SIZE,
   parameter int  STRIDE        = yolo_params_pkg::STRIDE,
   parameter int  NUM_CH        = yolo_params_pkg::NUM_CH,
   localparam int OFMAP_SIZE    = ofmap_size(IFMAP_SIZE, FILTER_SIZE, STRIDE),
   localparam int ACC_WIDTH     = acc_width(IP_DATA_WIDTH, FILTER_SIZE, NUM_CH),
`ifdef CONV_SAT_EN
   localparam int OUT_WIDTH     = 2 * IP_DATA_WIDTH,
`else
   localparam int OUT_WIDTH     = ACC_WIDTH,
`endif
   localparam int NTAP          = NUM_CH * FILTER_SIZE * FILTER_SIZE,
   localparam int ADDR_WIDTH    = cnt_width(NTAP),
   localparam int OC_WIDTH      = cnt_width(OFMAP_SIZE)
)(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flt_wr_en,
   input  logic [ADDR_WIDTH-1:0]           flt_wr_addr,
   input  logic [IP_DATA_WIDTH-1:0]        flt_wr_data,
   input  logic                            start,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_CH*IP_DATA_WIDTH-1:0] in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [OUT_WIDTH-1:0]            out_data,
   output logic [OC_WIDTH-1:0]             out_row,
   output logic [OC_WIDTH-1:0]             out_col,
   output logic                            busy,
   output logic                            done
);

   localparam int KK       = FILTER_SIZE * FILTER_SIZE;
   localparam int PW       = 2 * IP_DATA_WIDTH;
   localparam int RC_WIDTH = cnt_width(IFMAP_SIZE);

   conv_state_e                               state_q;
   logic [RC_WIDTH-1:0]                       row_q, col_q;
   logic                                      busy_q, done_q;
   logic [NTAP-1:0][IP_DATA_WIDTH-1:0]        flt_q;
   logic [NUM_CH-1:0][KK-1:0][IP_DATA_WIDTH-1:0] win;
   logic [NTAP-1:0][PW-1:0]                   prod_d, prod_q;
   logic [ACC_WIDTH-1:0]                      sum_d, sum_q;
   logic [OUT_WIDTH-1:0]                      out_d, out_q;
   logic [3:1]                                vld_q;
   logic [OC_WIDTH-1:0]                       orow_q, ocol_q;
   logic                                      stall, accept, trig, last_col, last_row;

   // A held output freezes the whole engine, so every stage moves in lockstep.
   assign stall    = vld_q[3] && !out_ready;
   assign in_ready = (state_q == STREAM) && !stall;
   assign accept   = in_valid && in_ready;
   assign last_col = (col_q == RC_WIDTH'(IFMAP_SIZE - 1));
   assign last_row = (row_q == RC_WIDTH'(IFMAP_SIZE - 1));

   always_comb begin
      trig = 1'b0;
      if (int'(row_q) >= FILTER_SIZE - 1 && int'(col_q) >= FILTER_SIZE - 1)
         trig = ((int'(row_q) - (FILTER_SIZE - 1)) % STRIDE == 0) &&
                ((int'(col_q) - (FILTER_SIZE - 1)) % STRIDE == 0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= STREAM;
                  busy_q  <= 1'b1;
                  row_q   <= '0;
                  col_q   <= '0;
               end
            end
            STREAM: begin
               if (accept) begin
                  if (last_col) begin
                     col_q <= '0;
                     if (last_row) begin
                        row_q   <= '0;
                        state_q <= FLUSH;
                     end else begin
                        row_q <= row_q + 1'b1;
                     end
                  end else begin
                     col_q <= col_q + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (vld_q == '0) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         flt_q <= '0;
      else if (flt_wr_en && state_q == IDLE && int'(flt_wr_addr) < NTAP)
         flt_q[flt_wr_addr] <= flt_wr_data;
   end

   conv_line_buffer #(
      .DW  (IP_DATA_WIDTH),
      .IFM (IFMAP_SIZE),
      .FS  (FILTER_SIZE),
      .NCH (NUM_CH)
   ) u_lb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (accept),
      .pix_i (in_data),
      .win_o (win)
   );

   // Tap t pairs coefficient ch*F*F + row*F + col with the same window position.
   always_comb begin
      prod_d = '0;
      for (int t = 0; t < NTAP; t++)
         prod_d[t] = PW'(win[t / KK][t % KK]) * PW'(flt_q[t]);
   end

   always_comb begin
      sum_d = '0;
      for (int t = 0; t < NTAP; t++)
         sum_d = sum_d + ACC_WIDTH'(prod_q[t]);
   end

`ifdef CONV_SAT_EN
   assign out_d = (sum_q > ACC_WIDTH'({PW{1'b1}})) ? {PW{1'b1}} : sum_q[PW-1:0];
`else
   assign out_d = sum_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= '0;
         prod_q <= '0;
         sum_q  <= '0;
         out_q  <= '0;
      end else if (!stall) begin
         vld_q  <= {vld_q[2:1], accept && trig};
         prod_q <= prod_d;
         sum_q  <= sum_d;
         out_q  <= out_d;
      end
   end

   // Outputs leave strictly in raster order, so the coordinate just counts handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         orow_q <= '0;
         ocol_q <= '0;
      end else if (vld_q[3] && out_ready) begin
         if (ocol_q == OC_WIDTH'(OFMAP_SIZE - 1)) begin
            ocol_q <= '0;
            orow_q <= (orow_q == OC_WIDTH'(OFMAP_SIZE - 1)) ? '0 : orow_q + 1'b1;
         end else begin
            ocol_q <= ocol_q + 1'b1;
         end
      end
   end

   assign out_valid = vld_q[3];
   assign out_data  = out_q;
   assign out_row   = orow_q;
   assign out_col   = ocol_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_conv_stream_engine.sv
// tb_conv_stream_engine: random frames, ready/valid gaps, stalls, intrusions and aborts
// checked against a direct sliding-window convolution of the frame.
module tb_conv_stream_engine;
   import yolo_params_pkg::*;

   localparam int DW   = IP_DATA_WIDTH;
   localparam int IFM  = IFMAP_SIZE;
   localparam int FS   = FILTER_SIZE;
   localparam int ST   = STRIDE;
   localparam int NCH  = NUM_CH;
   localparam int OFM  = (IFM - FS) / ST + 1;
   localparam int NTAP = NCH * FS * FS;
   localparam int ACCW = 2 * DW + $clog2(NTAP);
`ifdef CONV_SAT_EN
   localparam int OUTW = 2 * DW;
`else
   localparam int OUTW = ACCW;
`endif
   localparam int AW   = (NTAP > 1) ? $clog2(NTAP) : 1;
   localparam int OCW  = (OFM > 1) ? $clog2(OFM) : 1;
   localparam int NPIX = IFM * IFM;
   localparam int M_RVLD = 1, M_RRDY = 2, M_STALL = 4, M_INTRUDE = 8, M_ABORT = 16;

   logic              clk = 1'b0;
   logic              rst, flt_wr_en, start, in_valid, in_ready, out_valid, out_ready;
   logic              busy, done;
   logic [AW-1:0]     flt_wr_addr;
   logic [DW-1:0]     flt_wr_data;
   logic [NCH*DW-1:0] in_data;
   logic [OUTW-1:0]   out_data;
   logic [OCW-1:0]    out_row, out_col;

   int     checks = 0;
   int     failures = 0;
   longint cyc = 0;
   int     img [NCH][IFM][IFM];
   int     wt  [NCH][FS][FS];
   longint expv[OFM][OFM];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_stream_engine dut (
      .clk(clk), .rst(rst), .flt_wr_en(flt_wr_en), .flt_wr_addr(flt_wr_addr),
      .flt_wr_data(flt_wr_data), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: every window at the stride, summed over channels with plain integers.
   function automatic void model();
      for (int i = 0; i < OFM; i++)
         for (int j = 0; j < OFM; j++) begin
            longint s = 0;
            for (int c = 0; c < NCH; c++)
               for (int r = 0; r < FS; r++)
                  for (int k = 0; k < FS; k++)
                     s += longint'(img[c][i*ST+r][j*ST+k]) * longint'(wt[c][r][k]);
`ifdef CONV_SAT_EN
            if (s > (64'd1 << (2*DW)) - 1) s = (64'd1 << (2*DW)) - 1;
`endif
            expv[i][j] = s;
         end
   endfunction

   function automatic logic [NCH*DW-1:0] pix(input int p);
      logic [NCH*DW-1:0] v = '0;
      for (int c = 0; c < NCH; c++) v[c*DW +: DW] = DW'(img[c][p/IFM][p%IFM]);
      return v;
   endfunction

   // kind: 0 ones, 1 random, 2 max, 3 ramp on ch0 only
   task automatic fill_img(input int kind);
      for (int c = 0; c < NCH; c++)
         for (int r = 0; r < IFM; r++)
            for (int k = 0; k < IFM; k++)
               case (kind)
                  0: img[c][r][k] = 1;
                  1: img[c][r][k] = int'($urandom_range(0, (1 << DW) - 1));
                  2: img[c][r][k] = (1 << DW) - 1;
                  default: img[c][r][k] = (c == 0) ? ((r * IFM + k) % (1 << DW)) : 0;
               endcase
   endtask

   // kind: 0 ones, 1 random, 2 max, 3 centre tap of ch0, 4 zero
   task automatic fill_wt(input int kind);
      for (int c = 0; c < NCH; c++)
         for (int r = 0; r < FS; r++)
            for (int k = 0; k < FS; k++)
               case (kind)
                  0: wt[c][r][k] = 1;
                  1: wt[c][r][k] = int'($urandom_range(0, (1 << DW) - 1));
                  2: wt[c][r][k] = (1 << DW) - 1;
                  3: wt[c][r][k] = (c == 0 && r == FS/2 && k == FS/2) ? 1 : 0;
                  default: wt[c][r][k] = 0;
               endcase
   endtask

   task automatic load_weights();
      for (int c = 0; c < NCH; c++)
         for (int r = 0; r < FS; r++)
            for (int k = 0; k < FS; k++) begin
               flt_wr_en   = 1'b1;
               flt_wr_addr = AW'(c*FS*FS + r*FS + k);
               flt_wr_data = DW'(wt[c][r][k]);
               tick();
            end
      if (NTAP < (1 << AW)) begin
         flt_wr_addr = AW'(NTAP);
         flt_wr_data = '1;
         tick();
      end
      flt_wr_en = 1'b0;
   endtask

   task automatic run_frame(input int mode);
      int p = 0, n = 0, stall_left = 0;
      longint hs_cyc = -1, first_cyc = -1;
      bit done_seen = 0, stall_done = 0, prev_hold = 0;
      logic [OUTW-1:0] hold_d = '0;
      logic [OCW-1:0]  hold_r = '0, hold_c = '0;
      model();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int budget = 0; budget < 3000 && !done_seen; budget++) begin
         in_valid  = (p < NPIX) && ((mode & M_RVLD) == 0 || $urandom_range(0, 3) != 0);
         in_data   = (p < NPIX) ? pix(p) : (NCH*DW)'($urandom);
         if (stall_left > 0) out_ready = 1'b0;
         else out_ready = ((mode & M_RRDY) == 0) || ($urandom_range(0, 3) != 0);
         flt_wr_en = 1'b0;
         start     = 1'b0;
         if ((mode & M_INTRUDE) != 0 && p >= 10 && p < 14) begin
            flt_wr_en   = 1'b1;
            flt_wr_addr = AW'($urandom_range(0, NTAP - 1));
            flt_wr_data = DW'($urandom);
            start       = 1'b1;
         end
         @(negedge clk);
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, hold_d);
            chk("hold_row", out_row, hold_r);
            chk("hold_col", out_col, hold_c);
         end
         if (out_valid && !out_ready) chk("in_ready_in_stall", in_ready, 0);
         prev_hold = out_valid && !out_ready;
         hold_d = out_data; hold_r = out_row; hold_c = out_col;
         if (out_valid && first_cyc < 0) first_cyc = cyc;
         if (out_valid && out_ready) begin
            if (n < OFM*OFM) begin
               chk("out_row", out_row, n / OFM);
               chk("out_col", out_col, n % OFM);
               chk("out_data", out_data, expv[n/OFM][n%OFM]);
            end else begin
               chk("extra_output", n, OFM*OFM - 1);
            end
            n++;
         end
         if (in_valid && in_ready) begin
            if (p == (FS-1)*IFM + FS-1) hs_cyc = cyc;
            p++;
         end
         if ((mode & M_STALL) != 0 && !stall_done && n == 3) begin
            stall_left = 10;
            stall_done = 1;
         end else if (stall_left > 0) begin
            stall_left--;
         end
         if (done) done_seen = 1;
         if ((mode & M_ABORT) != 0 && p == 20) break;
         @(posedge clk);
         #1;
      end
      if ((mode & M_ABORT) != 0) begin
         rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         chk("abort_done", done, 0);
         chk("abort_busy", busy, 0);
         chk("abort_out_valid", out_valid, 0);
         chk("abort_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_seen = 1;
         end
         chk("abort_no_done", done_seen, 0);
         tick();
      end else begin
         chk("frame_done", done_seen, 1);
         chk("output_count", n, OFM*OFM);
         chk("pixel_count", p, NPIX);
         chk("first_out_latency", first_cyc - hs_cyc, 3);
         in_valid = 1'b0;
         @(negedge clk);
         chk("done_one_cycle", done, 0);
         chk("busy_idle", busy, 0);
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; flt_wr_en = 1'b0; flt_wr_addr = '0; flt_wr_data = '0;
      start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_row", out_row, 0);
      chk("rst_out_col", out_col, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick();

      fill_img(0); fill_wt(0); load_weights(); run_frame(0);
      fill_img(1); fill_wt(1); load_weights(); run_frame(M_RVLD | M_RRDY);
      fill_img(2); fill_wt(2); load_weights(); run_frame(M_RVLD);
      fill_img(3); fill_wt(3); load_weights(); run_frame(0);
      fill_img(1); fill_wt(1); load_weights(); run_frame(M_STALL);
      fill_img(1);                              run_frame(M_INTRUDE | M_RVLD);
      fill_img(1);                              run_frame(M_ABORT | M_RVLD);
      fill_img(1); fill_wt(4);                  run_frame(M_RVLD);
      fill_img(1); fill_wt(1); load_weights(); run_frame(M_RVLD | M_RRDY | M_STALL);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_stream_engine.md
Name: conv_stream_engine

Overview:
- Streaming, multi-channel successor to the combinational convolution datapath.
- Accepts an ifmap one pixel per handshake in raster order, all input channels in parallel, and buffers FILTER_SIZE-1 rows in line buffers.
- Forms FILTER_SIZE x FILTER_SIZE windows at the programmed STRIDE and sums products across all channels into one ofmap value.
- Emits ofmap values in raster order over a valid/ready port with backpressure. It sits between the ifmap fetch stage and the pooling/activation stages of the YOLO pipeline.

Parameters:
IP_DATA_WIDTH, 8, unsigned pixel and filter width
IFMAP_SIZE, 8, ifmap height = width
FILTER_SIZE, 3, kernel height = width (>=2)
STRIDE, 1, window step in rows and columns (>=1)
NUM_CH, 2, input channels summed into one output
OFMAP_SIZE, derived localparam: (IFMAP_SIZE-FILTER_SIZE)/STRIDE+1
ACC_WIDTH, derived localparam: 2*IP_DATA_WIDTH + $clog2(FILTER_SIZE*FILTER_SIZE*NUM_CH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
flt_wr_en  in  1  filter coefficient write strobe
flt_wr_addr  in  $clog2(NUM_CH*FILTER_SIZE*FILTER_SIZE)  flat index ch*F*F + row*F + col
flt_wr_data  in  IP_DATA_WIDTH  coefficient
start  in  1  begin one ifmap frame
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_data  in  NUM_CH*IP_DATA_WIDTH  channel c at bits [c*IP_DATA_WIDTH +: IP_DATA_WIDTH]
out_valid  out  1  ofmap value valid
out_ready  in  1  downstream accept
out_data  out  ACC_WIDTH (2*IP_DATA_WIDTH with CONV_SAT_EN)  ofmap value
out_row, out_col  out  $clog2(OFMAP_SIZE)  ofmap coordinate of out_data
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final output handshake

Behaviour:
- Reset values:
  - All outputs 0, FSM in IDLE, counters 0.
  - Line buffers and filter registers cleared to 0.
  - Reset asserted mid-frame aborts the frame; no done pulse is generated.
- FSM states and transitions:
  - IDLE: start -> STREAM. busy=0.
  - STREAM: accepts IFMAP_SIZE^2 pixels. After the last pixel is accepted -> FLUSH.
  - FLUSH: waits until the pipeline is empty and out_valid=0 -> IDLE, pulsing done for 1 cycle.
  - busy=1 in STREAM and FLUSH.
- Filter writes:
  - Accepted only in IDLE; ignored while busy.
  - Writes to addresses >= NUM_CH*F*F are ignored.
  - Coefficients are retained across frames.
  - start while busy is ignored.
- Pixel counters: col wraps at IFMAP_SIZE-1 and increments row; row wraps to 0 at end of frame.
- Window trigger: the accepted pixel (r,c) completes a window when all of the following hold:
  - r >= F-1 and c >= F-1
  - (r-F+1) % STRIDE == 0
  - (c-F+1) % STRIDE == 0
  - The window uses the current pixel plus line-buffer and shift-register contents; no data crosses row boundaries.
- Arithmetic: unsigned. Products are 2*IP_DATA_WIDTH wide. The adder tree is full-width into ACC_WIDTH, so there is no overflow.
- Pipeline: stage 1 multiplies, stage 2 sums, stage 3 is the output register. out_valid rises exactly 3 cycles after the triggering handshake when out_ready=1 throughout.
- Backpressure: global stall = out_valid && !out_ready.
  - A stall freezes all pipeline stages, line buffers and counters, and drives in_ready=0.
  - in_ready = (state==STREAM) && !stall.
  - out_data, out_row and out_col hold stable while out_valid && !out_ready.
- Output order: raster; out_row/out_col step 0..OFMAP_SIZE-1. Exactly OFMAP_SIZE^2 outputs per frame.

Optional Feature:
- CONV_SAT_EN defined: out_data is 2*IP_DATA_WIDTH wide. Sums above 2^(2*IP_DATA_WIDTH)-1 clamp to all-ones. Saturation is applied in stage 3 with no added latency.
- CONV_SAT_EN undefined: out_data is the full ACC_WIDTH sum.

Decomposition:
- yolo_params_pkg holds IP_DATA_WIDTH, IFMAP_SIZE, FILTER_SIZE, STRIDE, NUM_CH, and the derived OFMAP_SIZE/ACC_WIDTH functions.
- The FSM state enum (IDLE, STREAM, FLUSH) lives in the same package.
- One sub-module, conv_line_buffer: per-channel (FILTER_SIZE-1)-row delay line plus the FxF window shift registers, with a shared stall enable.

Test Plan:
- IFMAP 4, F=3, S=1, NUM_CH=1, all pixels 1, all weights 1 -> 4 outputs of 9 at (0,0),(0,1),(1,0),(1,1), then done; first out_valid 3 cycles after pixel (2,2).
- IFMAP 8, F=3, S=2, NUM_CH=2, ch0 pixel=r*8+c, ch1=0, centre weight 1, others 0 -> 9 outputs equal to ch0 at (2i+1,2j+1), e.g. out(1,2)=29.
- Max values 255 everywhere, NUM_CH=2, F=3 -> 18*65025=1170450 without CONV_SAT_EN; 65535 with it.
- out_ready held 0 for 10 cycles mid-frame -> in_ready=0, out_data stable, no pixel lost; final results match the no-stall run.
- rst asserted after 20 pixels, then a full new frame -> no done for the aborted frame; the new frame's outputs are correct (weights reloaded, since reset clears them).
- flt_wr_en and start during STREAM -> ignored; results use the weights loaded before start.
